tdm_demux: RTL and testbench

- Receive end of the 4-slot time-division link: deserialises the one-sample-per-clock TDM stream back into four parallel slot registers.
- The transmit side asserts frame_sync alongside the slot-0 sample. This block locks to that marker, tracks the slot position, and publishes a whole frame atomically.
- It also flags a sync error whenever the marker is misplaced or missing.

---
 rtl/tdm_demux.sv | 133 +++++++++++++
 tb/tb_tdm_demux.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - 4-slot TDM receive deserialiser with frame-sync lock tracking
module tdm_demux #(
  parameter int WIDTH            = 2,
  parameter bit SYNC_EVERY_FRAME = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             frame_valid,
  output logic             locked,
  output logic [1:0]       slot,
  output logic             sync_err
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic             locked_q, locked_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;
  logic [WIDTH-1:0] sh0_q, sh0_d;
  logic [WIDTH-1:0] sh1_q, sh1_d;
  logic [WIDTH-1:0] sh2_q, sh2_d;
  logic [WIDTH-1:0] out0_q, out0_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic [WIDTH-1:0] out2_q, out2_d;
  logic [WIDTH-1:0] out3_q, out3_d;

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    locked_d      = locked_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    sh0_d         = sh0_q;
    sh1_d         = sh1_q;
    sh2_d         = sh2_q;
    out0_d        = out0_q;
    out1_d        = out1_q;
    out2_d        = out2_q;
    out3_d        = out3_q;

    if (state_q == HUNT) begin
      if (frame_sync) begin
        sh0_d    = in;
        slot_d   = 2'd1;
        state_d  = LOCKED;
        locked_d = 1'b1;
      end
    end else if (frame_sync && slot_q != 2'd0) begin
      // Marker arrived early: drop the partial frame and restart at slot 0.
      sync_err_d = 1'b1;
      sh0_d      = in;
      slot_d     = 2'd1;
    end else begin
      case (slot_q)
        2'd0: begin
          if (frame_sync || !SYNC_EVERY_FRAME) begin
            sh0_d  = in;
            slot_d = 2'd1;
          end else begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
            locked_d   = 1'b0;
            slot_d     = 2'd0;
          end
        end
        2'd1: begin
          sh1_d  = in;
          slot_d = 2'd2;
        end
        2'd2: begin
          sh2_d  = in;
          slot_d = 2'd3;
        end
        default: begin
          out0_d        = sh0_q;
          out1_d        = sh1_q;
          out2_d        = sh2_q;
          out3_d        = in;
          frame_valid_d = 1'b1;
          slot_d        = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= HUNT;
      slot_q        <= 2'd0;
      locked_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      sh0_q         <= '0;
      sh1_q         <= '0;
      sh2_q         <= '0;
      out0_q        <= '0;
      out1_q        <= '0;
      out2_q        <= '0;
      out3_q        <= '0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      locked_q      <= locked_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      sh0_q         <= sh0_d;
      sh1_q         <= sh1_d;
      sh2_q         <= sh2_d;
      out0_q        <= out0_d;
      out1_q        <= out1_d;
      out2_q        <= out2_d;
      out3_q        <= out3_d;
    end
  end

  assign out0        = out0_q;
  assign out1        = out1_q;
  assign out2        = out2_q;
  assign out3        = out3_q;
  assign frame_valid = frame_valid_q;
  assign locked      = locked_q;
  assign slot        = slot_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - directed self-checking bench for tdm_demux (strict and free-running sync)
module tb_tdm_demux;

  logic       clk;
  logic       rst;
  logic [1:0] in_s;
  logic       fs_s;

  logic [1:0] a_out0, a_out1, a_out2, a_out3, a_slot;
  logic       a_fv, a_locked, a_se;
  logic [1:0] b_out0, b_out1, b_out2, b_out3, b_slot;
  logic       b_fv, b_locked, b_se;

  int checks;
  int failures;

  tdm_demux #(.WIDTH(2), .SYNC_EVERY_FRAME(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in(in_s), .frame_sync(fs_s),
    .out0(a_out0), .out1(a_out1), .out2(a_out2), .out3(a_out3),
    .frame_valid(a_fv), .locked(a_locked), .slot(a_slot), .sync_err(a_se)
  );

  tdm_demux #(.WIDTH(2), .SYNC_EVERY_FRAME(1'b0)) u_dut_free (
    .clk(clk), .rst(rst), .in(in_s), .frame_sync(fs_s),
    .out0(b_out0), .out1(b_out1), .out2(b_out2), .out3(b_out3),
    .frame_valid(b_fv), .locked(b_locked), .slot(b_slot), .sync_err(b_se)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs_a(input string tag, input logic [1:0] e0, input logic [1:0] e1,
                              input logic [1:0] e2, input logic [1:0] e3);
    check({tag, ".out0"}, a_out0, e0);
    check({tag, ".out1"}, a_out1, e1);
    check({tag, ".out2"}, a_out2, e2);
    check({tag, ".out3"}, a_out3, e3);
  endtask

  task automatic step(input logic [1:0] d, input logic fs);
    in_s = d;
    fs_s = fs;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] frm [3][4];

  initial begin
    checks   = 0;
    failures = 0;
    rst  = 1'b0;
    in_s = 2'b11;
    fs_s = 1'b1;

    // Reset values held while inputs are active
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_outs_a("rst", 2'd0, 2'd0, 2'd0, 2'd0);
      check("rst.fv", a_fv, 0);
      check("rst.locked", a_locked, 0);
      check("rst.slot", a_slot, 0);
      check("rst.se", a_se, 0);
    end
    rst = 1'b1;

    // Single-frame lock
    step(2'b01, 1'b1);
    check("lock.locked", a_locked, 1);
    check("lock.slot", a_slot, 1);
    check("lock.fv0", a_fv, 0);
    step(2'b10, 1'b0);
    step(2'b11, 1'b0);
    check("lock.fv2", a_fv, 0);
    step(2'b00, 1'b0);
    check("lock.fv", a_fv, 1);
    check("lock.slot_wrap", a_slot, 0);
    check_outs_a("lock", 2'b01, 2'b10, 2'b11, 2'b00);

    // Continuous streaming, three frames back to back
    frm[0] = '{2'b01, 2'b10, 2'b11, 2'b00};
    frm[1] = '{2'b11, 2'b00, 2'b01, 2'b10};
    for (int j = 0; j < 4; j++) frm[2][j] = 2'($urandom_range(0, 3));
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < 4; j++) begin
        step(frm[f][j], j == 0);
        check("stream.fv", a_fv, (j == 3) ? 1 : 0);
        check("stream.se", a_se, 0);
        check("stream.slot", a_slot, (j + 1) % 4);
        if (j == 3) check_outs_a("stream", frm[f][0], frm[f][1], frm[f][2], frm[f][3]);
      end
    end

    // Misaligned sync at slot 2
    step(2'b01, 1'b1);
    step(2'b10, 1'b0);
    step(2'b11, 1'b1);
    check("mis.se", a_se, 1);
    check("mis.fv", a_fv, 0);
    check("mis.slot", a_slot, 1);
    check("mis.locked", a_locked, 1);
    check_outs_a("mis.hold", frm[2][0], frm[2][1], frm[2][2], frm[2][3]);
    step(2'b00, 1'b0);
    check("mis.se_pulse", a_se, 0);
    step(2'b01, 1'b0);
    check("mis.fv_early", a_fv, 0);
    step(2'b10, 1'b0);
    check("mis.fv", a_fv, 1);
    check_outs_a("mis.new", 2'b11, 2'b00, 2'b01, 2'b10);

    // Reset mid-frame
    step(2'b01, 1'b1);
    step(2'b10, 1'b0);
    check("mrst.slot_pre", a_slot, 2);
    #2;
    rst = 1'b0;
    #1;
    check_outs_a("mrst.async", 2'd0, 2'd0, 2'd0, 2'd0);
    check("mrst.slot", a_slot, 0);
    check("mrst.locked", a_locked, 0);
    @(posedge clk);
    #1;
    check("mrst.fv", a_fv, 0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(2'b11, 1'b0);
      check("mrst.hunt_locked", a_locked, 0);
      check("mrst.hunt_slot", a_slot, 0);
      check("mrst.hunt_fv", a_fv, 0);
    end
    check_outs_a("mrst.hunt_out", 2'd0, 2'd0, 2'd0, 2'd0);
    step(2'b10, 1'b1);
    step(2'b01, 1'b0);
    step(2'b11, 1'b0);
    check("mrst.fv_early", a_fv, 0);
    step(2'b00, 1'b0);
    check("mrst.fv", a_fv, 1);
    check_outs_a("mrst.frame", 2'b10, 2'b01, 2'b11, 2'b00);

    // Missing sync: strict instance drops lock, free-running instance carries on
    step(2'b01, 1'b1);
    step(2'b10, 1'b0);
    step(2'b11, 1'b0);
    step(2'b00, 1'b0);
    check("miss.pre_fv_a", a_fv, 1);
    check("miss.pre_fv_b", b_fv, 1);
    step(2'b11, 1'b0);
    check("miss.se_a", a_se, 1);
    check("miss.locked_a", a_locked, 0);
    check("miss.slot_a", a_slot, 0);
    check("miss.se_b", b_se, 0);
    check("miss.locked_b", b_locked, 1);
    check("miss.slot_b", b_slot, 1);
    step(2'b00, 1'b0);
    check("miss.se_pulse_a", a_se, 0);
    step(2'b01, 1'b0);
    step(2'b10, 1'b0);
    check("miss.fv_a", a_fv, 0);
    check_outs_a("miss.hold_a", 2'b01, 2'b10, 2'b11, 2'b00);
    check("miss.fv_b", b_fv, 1);
    check("miss.se_b_end", b_se, 0);
    check("miss.b.out0", b_out0, 2'b11);
    check("miss.b.out1", b_out1, 2'b00);
    check("miss.b.out2", b_out2, 2'b01);
    check("miss.b.out3", b_out3, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
